// File: rtl/alu_sequencer.sv
// Accumulator controller for the 4-bit combinational ALU: accepts LOAD/EXEC/REPEAT/CLEAR
// commands and captures ALU result and flags into acc/c_flag/z_flag.
module alu_sequencer #(
  parameter int W             = 4,
  parameter int CNT_W         = 4,
  parameter bit STOP_ON_CARRY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_f,
  input  logic [W-1:0]     cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [2:0]       alu_f,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic [W-1:0]     acc,
  output logic             c_flag,
  output logic             z_flag,
  output logic             busy,
  output logic             done
);

  // Handshake: a command is taken at a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so a held cmd_valid waits without being dropped.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_EXEC   = 2'b01;
  localparam logic [1:0] OP_REPEAT = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [2:0]       f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             z_q, z_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f_d       = f_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    z_d       = z_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD: begin
              acc_d   = cmd_data;
              c_d     = 1'b0;
              z_d     = (cmd_data == '0);
              state_d = ST_DONE;
            end
            OP_CLEAR: begin
              acc_d   = '0;
              c_d     = 1'b0;
              z_d     = 1'b1;
              state_d = ST_DONE;
            end
            OP_EXEC: begin
              f_d     = cmd_f;
              opnd_d  = cmd_data;
              cnt_d   = CNT_W'(1);
              state_d = ST_RUN;
            end
            OP_REPEAT: begin
              f_d     = cmd_f;
              opnd_d  = cmd_data;
              cnt_d   = cmd_count;
              state_d = (cmd_count == '0) ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        acc_d = alu_y;
        c_d   = alu_carry;
        z_d   = alu_zero;
        // Saturate at zero so the counter can never wrap around.
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if ((cnt_q <= CNT_W'(1)) || (STOP_ON_CARRY && alu_carry)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_f  = f_q;
  assign alu_a  = acc_q;
  assign alu_b  = opnd_q;
  assign acc    = acc_q;
  assign c_flag = c_q;
  assign z_flag = z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: two instances (STOP_ON_CARRY off/on) share the
// command bus; each drives its own add/xor ALU model.
module tb_alu_sequencer;

  localparam int W     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_f;
  logic [W-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_count;

  logic [2:0]   alu_f0, alu_f1;
  logic [W-1:0] alu_a0, alu_a1, alu_b0, alu_b1, alu_y0, alu_y1;
  logic         alu_c0, alu_c1, alu_z0, alu_z1;
  logic [W-1:0] acc0, acc1;
  logic         rdy0, rdy1, cf0, cf1, zf0, zf1, busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W), .CNT_W(CNT_W), .STOP_ON_CARRY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_op(cmd_op), .cmd_f(cmd_f), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .alu_f(alu_f0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_y(alu_y0),
    .alu_carry(alu_c0), .alu_zero(alu_z0), .acc(acc0), .c_flag(cf0),
    .z_flag(zf0), .busy(busy0), .done(done0)
  );

  alu_sequencer #(.W(W), .CNT_W(CNT_W), .STOP_ON_CARRY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_f(cmd_f), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .alu_f(alu_f1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_y(alu_y1),
    .alu_carry(alu_c1), .alu_zero(alu_z1), .acc(acc1), .c_flag(cf1),
    .z_flag(zf1), .busy(busy1), .done(done1)
  );

  // ALU model: f=011 adds with carry out of bit W; other codes xor with no carry.
  always_comb begin
    if (alu_f0 == 3'b011) {alu_c0, alu_y0} = {1'b0, alu_a0} + {1'b0, alu_b0};
    else                  {alu_c0, alu_y0} = {1'b0, alu_a0 ^ alu_b0};
    alu_z0 = (alu_y0 == '0);
    if (alu_f1 == 3'b011) {alu_c1, alu_y1} = {1'b0, alu_a1} + {1'b0, alu_b1};
    else                  {alu_c1, alu_y1} = {1'b0, alu_a1 ^ alu_b1};
    alu_z1 = (alu_y1 == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for both instances to be ready, presents one command for one edge.
  task automatic send_cmd(input logic [1:0] op, input logic [2:0] f,
                          input logic [W-1:0] data, input logic [CNT_W-1:0] count);
    int guard = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    cmd_op    = op;
    cmd_f     = f;
    cmd_data  = data;
    cmd_count = count;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts negedges since the accept edge until the selected instance shows done.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? done1 : done0) && n < 40);
  endtask

  int n;
  logic [W-1:0] trace [4];

  initial begin
    trace[0] = 4'h4; trace[1] = 4'h7; trace[2] = 4'hA; trace[3] = 4'hD;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_f = '0; cmd_data = '0; cmd_count = '0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_acc", acc0, 0);
    check("rst_c", cf0, 0);
    check("rst_z", zf0, 0);
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);

    // 2. LOAD 3, EXEC add 2
    send_cmd(2'b00, 3'b000, 4'h3, 4'd0);
    wait_done(1'b0, n);
    check("load_lat", n, 1);
    check("load_acc", acc0, 4'h3);
    check("load_z", zf0, 0);
    send_cmd(2'b01, 3'b011, 4'h2, 4'd0);
    @(negedge clk);
    check("exec_run_ready", rdy0, 0);
    check("exec_run_busy", busy0, 1);
    check("exec_run_done", done0, 0);
    @(negedge clk);
    check("exec_done", done0, 1);
    check("exec_done_ready", rdy0, 0);
    check("exec_acc", acc0, 4'h5);
    check("exec_c", cf0, 0);
    check("exec_z", zf0, 0);
    @(negedge clk);
    check("exec_done_pulse", done0, 0);
    check("exec_idle_ready", rdy0, 1);

    // 3. LOAD 1, REPEAT add 3 x4
    send_cmd(2'b00, 3'b000, 4'h1, 4'd0);
    wait_done(1'b0, n);
    send_cmd(2'b10, 3'b011, 4'h3, 4'd4);
    @(negedge clk);
    check("rep_c1_acc", acc0, 4'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rep_acc_%0d", i), acc0, trace[i]);
      check($sformatf("rep_done_%0d", i), done0, (i == 3) ? 1 : 0);
    end
    check("rep_c", cf0, 0);

    // 4. REPEAT count 0: no capture, straight to DONE
    send_cmd(2'b10, 3'b011, 4'h7, 4'd0);
    @(negedge clk);
    check("rep0_done", done0, 1);
    check("rep0_acc", acc0, 4'hD);
    check("rep0_c", cf0, 0);
    check("rep0_z", zf0, 0);
    check("rep0_opnd", alu_b0, 4'h7);
    @(negedge clk);
    check("rep0_idle", rdy0, 1);
    check("rep0_acc_after", acc0, 4'hD);

    // 5. LOAD E, REPEAT add 1 x5: dut1 stops on carry, dut0 runs all 5
    send_cmd(2'b00, 3'b000, 4'hE, 4'd0);
    wait_done(1'b0, n);
    send_cmd(2'b10, 3'b011, 4'h1, 4'd5);
    wait_done(1'b1, n);
    check("soc_lat", n, 3);
    check("soc_acc", acc1, 4'h0);
    check("soc_c", cf1, 1);
    check("soc_z", zf1, 1);
    wait_done(1'b0, n);
    check("nosoc_lat", n, 3);
    check("nosoc_acc", acc0, 4'h3);
    check("nosoc_c", cf0, 0);
    check("nosoc_z", zf0, 0);

    // CLEAR
    send_cmd(2'b11, 3'b000, 4'h9, 4'd0);
    wait_done(1'b0, n);
    check("clr_lat", n, 1);
    check("clr_acc", acc0, 0);
    check("clr_z", zf0, 1);
    check("clr_c", cf0, 0);

    // 6. reset during 2nd RUN cycle with a LOAD 9 held on the bus
    send_cmd(2'b00, 3'b000, 4'h2, 4'd0);
    wait_done(1'b0, n);
    send_cmd(2'b10, 3'b011, 4'h1, 4'd5);
    cmd_op = 2'b00; cmd_data = 4'h9; cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_acc", acc0, 4'h3);
    check("mid_run_busy", busy0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_acc", acc0, 0);
    check("mrst_done", done0, 0);
    check("mrst_busy", busy0, 0);
    check("mrst_c", cf0, 0);
    reset = 1'b0;
    @(negedge clk);
    check("held_done", done0, 1);
    check("held_acc", acc0, 4'h9);
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
